pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 122 ++++++++++++
 tb/tb_pwm_multi.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: several PWM channels sharing one period counter.
// Period, compares and mode are written into shadow registers at any time.
// They reach the running (active) set only at a period boundary, so a period
// in progress is never disturbed. Two counting styles are supported:
// edge-aligned (sawtooth) and center-aligned (triangle, 2P cycles).
module pwm_multi #(
   parameter int                  XLEN     = 3,
   parameter int                  CHANNELS = 2,
   parameter logic [CHANNELS-1:0] POL      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     load,
   input  logic [XLEN-1:0]          period_in,
   input  logic [CHANNELS*XLEN-1:0] cmp_in,
   input  logic                     mode_in,
   output logic [CHANNELS-1:0]      signal,
   output logic                     period_end
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   logic [XLEN-1:0]          period_shadow, period_active;
   logic [CHANNELS*XLEN-1:0] cmp_shadow, cmp_active;
   logic                     mode_shadow, mode_active;

   logic [XLEN-1:0] cnt, cnt_next, last;
   dir_t            dir, dir_next;
   logic            boundary;
   logic [CHANNELS-1:0] raw;

   // Last count value of the up phase; unused when the period is zero.
   assign last = period_active - 1'b1;

   // Next counter/direction state and boundary detection for the active mode.
   always_comb begin
      boundary = 1'b0;
      cnt_next = cnt;
      dir_next = dir;
      if (period_active == '0) begin
         // Degenerate period: counter parked at 0, every cycle ends a period.
         boundary = 1'b1;
         cnt_next = '0;
         dir_next = DIR_UP;
      end else if (!mode_active) begin
         if (cnt == last) begin
            boundary = 1'b1;
            cnt_next = '0;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end else if (dir == DIR_UP) begin
         // At the top the count is held for one cycle while turning around.
         if (cnt == last) begin
            dir_next = DIR_DOWN;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end else begin
         if (cnt == '0) begin
            boundary = 1'b1;
            cnt_next = '0;
            dir_next = DIR_UP;
         end else begin
            cnt_next = cnt - 1'b1;
         end
      end
   end

   // Per-channel compare against the pre-update count, with polarity applied.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign raw[gi] = (cnt < cmp_active[gi*XLEN +: XLEN]) ^ POL[gi];
   end

   // Shadow registers: written on every load strobe, independent of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_shadow <= '0;
         cmp_shadow    <= '0;
         mode_shadow   <= 1'b0;
      end else if (load) begin
         period_shadow <= period_in;
         cmp_shadow    <= cmp_in;
         mode_shadow   <= mode_in;
      end
   end

   // Counter, direction and active set; active copies shadow only on a boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         dir           <= DIR_UP;
         period_active <= '0;
         cmp_active    <= '0;
         mode_active   <= 1'b0;
      end else if (en) begin
         cnt <= cnt_next;
         dir <= dir_next;
         if (boundary) begin
            period_active <= period_shadow;
            cmp_active    <= cmp_shadow;
            mode_active   <= mode_shadow;
         end
      end
   end

   // Registered outputs: idle level is the channel polarity when disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         signal     <= POL;
         period_end <= 1'b0;
      end else if (en) begin
         signal     <= raw;
         period_end <= boundary;
      end else begin
         signal     <= POL;
         period_end <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scoreboard bench for pwm_multi.
// Two instances share all inputs: one with POL=00, one with POL=10. The
// stimulus side pushes the hand-derived expected (POL=00) output for each
// clock; the monitor pops one entry per clock and checks both instances,
// applying the polarity to the second.
module tb_pwm_multi;

   localparam logic [1:0] POL_B = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [2:0] period_in = '0;
   logic [5:0] cmp_in = '0;
   logic       mode_in = 1'b0;
   logic [1:0] signal_a, signal_b;
   logic       period_end_a, period_end_b;

   typedef struct packed {
      logic [1:0] sig;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   ph = 0;

   always #5 clk = ~clk;

   pwm_multi #(.XLEN(3), .CHANNELS(2), .POL(2'b00)) dut_a (
      .clk(clk), .rst(rst), .en(en), .load(load), .period_in(period_in),
      .cmp_in(cmp_in), .mode_in(mode_in), .signal(signal_a), .period_end(period_end_a)
   );

   pwm_multi #(.XLEN(3), .CHANNELS(2), .POL(POL_B)) dut_b (
      .clk(clk), .rst(rst), .en(en), .load(load), .period_in(period_in),
      .cmp_in(cmp_in), .mode_in(mode_in), .signal(signal_b), .period_end(period_end_b)
   );

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, req);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, " sig_a"}, signal_a, e.sig);
      chk({tag, " pe_a"}, {1'b0, period_end_a}, {1'b0, e.pe});
      chk({tag, " sig_b"}, signal_b, e.sig ^ POL_B);
      chk({tag, " pe_b"}, {1'b0, period_end_b}, {1'b0, e.pe});
   endtask

   // Monitor: one expected entry per clock, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_all("cycle", cur);
            $display("t=%0t rst=%b en=%b sig_a=%b pe_a=%b sig_b=%b pe_b=%b exp=%b/%b",
                     $time, rst, en, signal_a, period_end_a, signal_b, period_end_b,
                     cur.sig, cur.pe);
         end
      end
   end

   // Drive one clock of stimulus and queue the output expected after that edge.
   task automatic drive(input logic e, input logic ld, input logic [1:0] s, input logic pe);
      exp_t x;
      @(negedge clk);
      en   = e;
      load = ld;
      x.sig = s;
      x.pe  = pe;
      exp_q.push_back(x);
   endtask

   // Reset (checked immediately), then load a configuration. The two edges
   // after release are boundaries of the zero period; the loaded values are
   // active from the third edge on, which starts pattern phase 0.
   task automatic start(input logic [2:0] p, input logic [2:0] c0, input logic [2:0] c1,
                        input logic m);
      exp_t x;
      @(negedge clk);
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      #1;
      x.sig = 2'b00;
      x.pe  = 1'b0;
      check_all("reset_now", x);
      exp_q.push_back(x);
      drive(1'b0, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      period_in = p;
      cmp_in    = {c1, c0};
      mode_in   = m;
      en        = 1'b1;
      load      = 1'b1;
      x.sig = 2'b00;
      x.pe  = 1'b1;
      exp_q.push_back(x);
      drive(1'b1, 1'b0, 2'b00, 1'b1);
      ph = 0;
   endtask

   // Run n enabled clocks following a hand-written per-period pattern
   // (MSB first, len bits); period_end is expected on the last phase.
   task automatic run(input logic [7:0] p0, input logic [7:0] p1, input int len,
                      input int n, input logic ld_first);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, (i == 0) && ld_first, {p1[len-1-ph], p0[len-1-ph]}, ph == len - 1);
         ph = (ph + 1) % len;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);

      // Edge mode P=7 cmp0=4 cmp1=0: 1111000 / constant 0.
      start(3'd7, 3'd4, 3'd0, 1'b0);
      run(8'b01111000, 8'b0, 7, 21, 1'b0);
      // Mid-period compare change at cnt=2 takes effect next period.
      run(8'b01111000, 8'b0, 7, 2, 1'b0);
      cmp_in = {3'd0, 3'd2};
      run(8'b01111000, 8'b0, 7, 5, 1'b1);
      // Freeze at cnt=3 for three cycles, then resume without skipping.
      run(8'b01100000, 8'b0, 7, 3, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 2'b00, 1'b0);
      run(8'b01100000, 8'b0, 7, 4, 1'b0);
      run(8'b01100000, 8'b0, 7, 7, 1'b0);

      // 100% duty on channel 0 (cmp == P).
      start(3'd7, 3'd7, 3'd0, 1'b0);
      run(8'b01111111, 8'b0, 7, 14, 1'b0);
      // 0% on channel 0, 100% on channel 1.
      start(3'd7, 3'd0, 3'd7, 1'b0);
      run(8'b0, 8'b01111111, 7, 14, 1'b0);
      // cmp > P on channel 0, P=5 cmp1=2 on channel 1.
      start(3'd5, 3'd6, 3'd2, 1'b0);
      run(8'b00011111, 8'b00011000, 5, 10, 1'b0);

      // Center mode P=4 cmp0=2: 11000011 over 8 cycles.
      start(3'd4, 3'd2, 3'd0, 1'b1);
      run(8'b11000011, 8'b0, 8, 16, 1'b0);

      // cmp1=3 P=7, reset pulsed mid-period; inverted channel reads 0001111.
      start(3'd7, 3'd0, 3'd3, 1'b0);
      run(8'b0, 8'b01110000, 7, 3, 1'b0);
      start(3'd7, 3'd0, 3'd3, 1'b0);
      run(8'b0, 8'b01110000, 7, 14, 1'b0);

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0 entries", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
